key_reader: RTL

//  Input-side companion to the LED output drivers: samples the board's raw active-low

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_reader_if.sv | 34 +++
 rtl/key_debounce.sv | 145 ++++++++++++++
 rtl/key_reader.sv | 53 +++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key_reader pushbutton front end.
//   key_st_t          per-channel debounce FSM state (REL, PRESS_WAIT, HELD, REL_WAIT)
//   DEF_* constants   default cycle counts for a 50 MHz CLOCK_50
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        REL        = 2'd0,  // released, idle
        PRESS_WAIT = 2'd1,  // pressed level seen, waiting for it to stay stable
        HELD       = 2'd2,  // accepted press
        REL_WAIT   = 2'd3   // released level seen while held, waiting for stability
    } key_st_t;

    localparam int DEF_NUM_KEYS             = 4;
    localparam int DEF_DEBOUNCE_CYCLES      = 500_000;     // 10 ms
    localparam int DEF_REPEAT_DELAY_CYCLES  = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD_CYCLES = 5_000_000;   // 100 ms

endpackage

// File: rtl/key_reader_if.sv
// -----------------------------------------------------------------------------
// key_reader_if
// Bundles the key pins and the cleaned-up key outputs.
//   KEY          raw active-low pushbuttons (0 = pressed), asynchronous
//   key_state    debounced level, 1 = pressed
//   key_press    single-cycle pulse on accepted press (and on auto-repeat)
//   key_release  single-cycle pulse on accepted release
//   key_fsm      per-channel FSM state, for observation only
// Signalling: there is no valid/ready handshake here. key_state is a level;
// key_press/key_release are one-cycle strobes that the consumer must sample
// on every CLOCK_50 edge, and there is no back-pressure.
// Modports: slave = key_reader side, master = the user/board side.
// -----------------------------------------------------------------------------
interface key_reader_if
    import key_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS
);
    logic    [NUM_KEYS-1:0] KEY;
    logic    [NUM_KEYS-1:0] key_state;
    logic    [NUM_KEYS-1:0] key_press;
    logic    [NUM_KEYS-1:0] key_release;
    key_st_t [NUM_KEYS-1:0] key_fsm;

    modport slave (
        input  KEY,
        output key_state, key_press, key_release, key_fsm
    );

    modport master (
        output KEY,
        input  key_state, key_press, key_release, key_fsm
    );
endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One pushbutton channel: 2-FF synchroniser, debounce FSM, stability counter,
// registered press/release pulses, optional auto-repeat.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat press pulses while held).
// Ports:
//   clk          CLOCK_50
//   rst_n        asynchronous active-low reset (deassert synchronously upstream)
//   key_n        raw active-low key pin
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse on accepted press / repeat
//   key_release  one-cycle pulse on accepted release
//   state_dbg    current FSM state
// -----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    key_n,
    output logic    key_state,
    output logic    key_press,
    output logic    key_release,
    output key_st_t state_dbg
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 1 ||
        REPEAT_PERIOD_CYCLES > REPEAT_DELAY_CYCLES) begin : g_bad_cfg
        $error("key_debounce: invalid cycle parameters");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // The sample that moves REL/HELD into a *_WAIT state is the first stable
    // cycle and the accepting sample is the last one, so the counter only has
    // to cover the DEBOUNCE_CYCLES-2 samples in between.
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             sync1, sync2;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt;
    key_st_t          state;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY_CYCLES + 1);
    // Fire when the counter has seen REPEAT_DELAY_CYCLES-1 held cycles, then
    // reload so the next fire is REPEAT_PERIOD_CYCLES later; it never wraps.
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);
    logic [RPT_W-1:0] rpt_cnt;
`endif

    // Released is the safe power-up value for an active-low pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REL;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
            // Any state other than HELD keeps the repeat delay restarted.
            if (state != HELD) begin
                rpt_cnt <= '0;
            end
`endif
            case (state)
                REL: begin
                    if (pressed_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state     <= HELD;
                        cnt       <= '0;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed_s) begin
                        state <= REL_WAIT;
                        cnt   <= '0;
`ifdef KEY_REPEAT_EN
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == RPT_FIRE) begin
                        key_press <= 1'b1;
                        rpt_cnt   <= RPT_RELOAD;
                    end else begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
`endif
                    end
                end
                REL_WAIT: begin
                    if (pressed_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state       <= REL;
                        cnt         <= '0;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_reader.sv
// -----------------------------------------------------------------------------
// key_reader
// Samples the board's active-low pushbuttons, synchronises and debounces each
// one independently, and presents a clean level plus press/release pulses on
// the CLOCK_50 domain. Pin edge to event latency is 2 + DEBOUNCE_CYCLES.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat key_press while held).
// Ports:
//   CLOCK_50   50 MHz system clock
//   RESET_N    asynchronous active-low reset; release is expected to be
//              synchronous to CLOCK_50
//   kif        key_reader_if.slave: KEY in; key_state, key_press,
//              key_release, key_fsm out
// -----------------------------------------------------------------------------
module key_reader
    import key_pkg::*;
#(
    parameter int NUM_KEYS             = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    key_reader_if.slave   kif
);

    logic    [NUM_KEYS-1:0] ch_state;
    logic    [NUM_KEYS-1:0] ch_press;
    logic    [NUM_KEYS-1:0] ch_release;
    key_st_t [NUM_KEYS-1:0] ch_fsm;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_debounce (
            .clk         (CLOCK_50),
            .rst_n       (RESET_N),
            .key_n       (kif.KEY[i]),
            .key_state   (ch_state[i]),
            .key_press   (ch_press[i]),
            .key_release (ch_release[i]),
            .state_dbg   (ch_fsm[i])
        );
    end

    assign kif.key_state   = ch_state;
    assign kif.key_press   = ch_press;
    assign kif.key_release = ch_release;
    assign kif.key_fsm     = ch_fsm;

endmodule
